// File: rtl/sign_ext.sv
// sign_ext: registered immediate generator / sign extender for the RV64 datapath.
// Decodes the base opcode, assembles the format-specific immediate and
// sign-extends it to XLEN. One cycle of latency and no combinational path
// from instruction to the outputs.
module sign_ext #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     instruction,
  output logic [XLEN-1:0] seinst,
  output logic            imm_valid
);

  // Base opcodes recognised by the decoder
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;

  // funct3 values that turn OP-IMM / OP-IMM-32 into shift-amount forms
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRL = 3'b101;

  logic [6:0]        opcode_s;
  logic [2:0]        funct3_s;
  logic              sign_s;
  logic [31:0]       imm32_s;
  logic              valid_d;
  logic [XLEN-1:0]   seinst_d;
  logic [XLEN-1:0]   seinst_q;
  logic              valid_q;

  assign opcode_s = instruction[6:0];
  assign funct3_s = instruction[14:12];
  assign sign_s   = instruction[31];

  // Assemble the immediate as a 32-bit value already extended to bit 31
  // (shamt forms carry zeros above their field); widening to XLEN then only
  // needs to replicate bit 31, which keeps XLEN = 32 legal.
  always_comb begin
    imm32_s = 32'd0;
    valid_d = 1'b0;
    case (opcode_s)
      OPC_OP_IMM: begin
        valid_d = 1'b1;
        if ((funct3_s == F3_SLL) || (funct3_s == F3_SRL)) begin
          imm32_s = {26'd0, instruction[25:20]};
        end else begin
          imm32_s = {{20{sign_s}}, instruction[31:20]};
        end
      end
      OPC_OP_IMM32: begin
        valid_d = 1'b1;
        if ((funct3_s == F3_SLL) || (funct3_s == F3_SRL)) begin
          imm32_s = {27'd0, instruction[24:20]};
        end else begin
          imm32_s = {{20{sign_s}}, instruction[31:20]};
        end
      end
      OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
        valid_d = 1'b1;
        imm32_s = {{20{sign_s}}, instruction[31:20]};
      end
      OPC_STORE: begin
        valid_d = 1'b1;
        imm32_s = {{20{sign_s}}, instruction[31:25], instruction[11:7]};
      end
      OPC_BRANCH: begin
        valid_d = 1'b1;
        imm32_s = {{19{sign_s}}, instruction[31], instruction[7],
                   instruction[30:25], instruction[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        valid_d = 1'b1;
        imm32_s = {instruction[31:12], 12'd0};
      end
      OPC_JAL: begin
        valid_d = 1'b1;
        imm32_s = {{11{sign_s}}, instruction[31], instruction[19:12],
                   instruction[20], instruction[30:21], 1'b0};
      end
      default: begin
        valid_d = 1'b0;
        imm32_s = 32'd0;
      end
    endcase
  end

  // Widen the assembled immediate to XLEN by replicating bit 31
  always_comb begin
    seinst_d = {XLEN{imm32_s[31]}};
    seinst_d[31:0] = imm32_s;
  end

  // Output register: async clear, otherwise capture a fresh decode every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seinst_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      seinst_q <= seinst_d;
      valid_q  <= valid_d;
    end
  end

  assign seinst    = seinst_q;
  assign imm_valid = valid_q;

endmodule

// File: tb/tb_sign_ext.sv
// tb_sign_ext: directed bench for sign_ext with a queue-based scoreboard.
module tb_sign_ext;

  logic        clk;
  logic        rst_n;
  logic [31:0] instruction;
  logic [63:0] seinst;
  logic        imm_valid;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_seinst_q[$];
  logic        exp_valid_q[$];

  sign_ext #(.XLEN(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruction (instruction),
    .seinst      (seinst),
    .imm_valid   (imm_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Apply an instruction and record what the next edge must produce
  task automatic drive(input logic [31:0] inst, input logic [63:0] exp_se, input logic exp_v);
    instruction = inst;
    exp_seinst_q.push_back(exp_se);
    exp_valid_q.push_back(exp_v);
  endtask

  // Let one edge pass and compare the DUT against the oldest expectation
  task automatic capture(input string tag);
    logic [63:0] e_se;
    logic        e_v;
    @(posedge clk);
    #1;
    if (exp_seinst_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
    end else begin
      e_se = exp_seinst_q.pop_front();
      e_v  = exp_valid_q.pop_front();
      check64({tag, "_seinst"}, seinst, e_se);
      check1({tag, "_valid"}, imm_valid, e_v);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    instruction = 32'hFFF00093;
    #3;
    // Reset clears outputs before any clock edge
    check64("reset_seinst", seinst, 64'h0);
    check1("reset_valid", imm_valid, 1'b0);
    @(posedge clk);
    #1;
    check64("reset_hold_seinst", seinst, 64'h0);
    check1("reset_hold_valid", imm_valid, 1'b0);
    #2;
    rst_n = 1'b1;

    drive(32'h004E3103, 64'h0000000000000004, 1'b1); capture("ld");
    drive(32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 1'b1); capture("addi_neg");
    drive(32'h03F09093, 64'h000000000000003F, 1'b1); capture("slli63");
    drive(32'h43F0D093, 64'h000000000000003F, 1'b1); capture("srai63");
    drive(32'h0210909B, 64'h0000000000000001, 1'b1); capture("slliw_bit25");
    drive(32'h8000009B, 64'hFFFFFFFFFFFFF800, 1'b1); capture("addiw_min");
    drive(32'hFE21BC23, 64'hFFFFFFFFFFFFFFF8, 1'b1); capture("sd_neg");
    drive(32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, 1'b1); capture("beq_neg");
    drive(32'h800000B7, 64'hFFFFFFFF80000000, 1'b1); capture("lui_neg");
    drive(32'h00001017, 64'h0000000000001000, 1'b1); capture("auipc");
    drive(32'h0080006F, 64'h0000000000000008, 1'b1); capture("jal");
    drive(32'h00000073, 64'h0000000000000000, 1'b1); capture("ecall_zero");
    drive(32'h0000007F, 64'h0000000000000000, 1'b0); capture("unknown");

    // Outputs must hold while the instruction toggles between edges
    instruction = 32'hFFF00093;
    #2;
    check64("hold_seinst_a", seinst, 64'h0);
    check1("hold_valid_a", imm_valid, 1'b0);
    instruction = 32'h800000B7;
    #2;
    check64("hold_seinst_b", seinst, 64'h0);
    check1("hold_valid_b", imm_valid, 1'b0);
    // The value present at the edge is what gets captured
    drive(32'hFE21BC23, 64'hFFFFFFFFFFFFFFF8, 1'b1); capture("after_toggle");

    // Asynchronous reset pulse between edges
    drive(32'h0080006F, 64'h0000000000000008, 1'b1); capture("pre_reset_jal");
    instruction = 32'h800000B7;
    #2;
    rst_n = 1'b0;
    #1;
    check64("async_rst_seinst", seinst, 64'h0);
    check1("async_rst_valid", imm_valid, 1'b0);
    #1;
    rst_n = 1'b1;
    drive(32'h800000B7, 64'hFFFFFFFF80000000, 1'b1); capture("post_reset_lui");
    drive(32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, 1'b1); capture("post_reset_beq");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
